// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_sync data memory.
// Holds the access-size encodings carried on size_i and the controller
// state enum. The top module and the testbench both import it.
package dmem_pkg;

    // Access size encodings (size_i)
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_sync_if.sv
// Request/response bus of the dmem_sync data memory.
//   req_i      access request, sampled only while busy_o is low
//   we_i       1 = write, 0 = read
//   size_i     0 = byte, 1 = half, 2 = word, 3 = reserved
//   unsigned_i read extension: 1 = zero-extend, 0 = sign-extend
//   addr_i     byte address, little-endian
//   data_i     right-aligned write data
//   busy_o     accepted access in flight
//   valid_o    one-cycle completion pulse
//   data_o     extended read data, 0 for writes and errors
//   err_o      one-cycle pulse for a rejected access
// master = requester side, slave = memory side.
interface dmem_sync_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, data_i,
        input  busy_o, valid_o, data_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, data_i,
        output busy_o, valid_o, data_o, err_o
    );
endinterface

// File: rtl/dmem_byte_ram.sv
// Word-organised storage built from four independent byte lanes.
// Ports:
//   clk    write clock
//   addr   word address (shared by read and write)
//   be     per-lane write enable, lane 0 = bits [7:0]
//   wdata  lane-replicated write data
//   rdata  combinational read of the addressed word
// Contents are not reset.
module dmem_byte_ram #(
    parameter int DEPTH_WORDS = 32,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (be[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/dmem_sync.sv
// Data memory with a fixed, parameterised access latency.
// An accepted request is latched, held for LATENCY edges, then performed
// (write committed or read captured) and reported with a one-cycle
// valid_o or err_o pulse.
// Parameters:
//   DEPTH_WORDS  memory size in 32-bit words (power of two, 4..4096)
//   LATENCY      edges from acceptance to completion (1..7)
// Ports:
//   clk_i  clock, all state changes on the rising edge
//   rst_i  asynchronous active-low reset
//   bus    request/response bus (slave side)
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_sync_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  size_reg;
    logic        we_reg;
    logic        uns_reg;
    logic        busy_reg;
    logic        valid_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    logic        complete;
    logic        range_err;
    logic        access_err;
    logic [3:0]  lane_be;
    logic [3:0]  ram_be;
    logic [31:0] lane_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] aligned;
    logic [31:0] read_ext;

    // Any address bit above the array span means the byte is out of range.
    assign range_err = |addr_reg[31:AW+2];

    always_comb begin
        access_err = range_err;
        case (size_reg)
            SZ_HALF: if (addr_reg[0])         access_err = 1'b1;
            SZ_WORD: if (addr_reg[1:0] != 0)  access_err = 1'b1;
            SZ_RSVD:                          access_err = 1'b1;
            default: ;
        endcase
    end

    // The access is performed on the edge where the countdown sits at zero.
    assign complete = (state_reg == ST_WAIT) && (cnt_reg == 3'd0);

    // Lane enables and lane-replicated write data; alignment was already
    // checked, so a half never straddles lanes 1/2.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = 32'd0;
        case (size_reg)
            SZ_BYTE: begin
                lane_be    = 4'b0001 << addr_reg[1:0];
                lane_wdata = {4{wdata_reg[7:0]}};
            end
            SZ_HALF: begin
                lane_be    = addr_reg[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_reg[15:0]}};
            end
            SZ_WORD: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_reg;
            end
            default: ;
        endcase
    end

    assign ram_be = (complete && we_reg && !access_err) ? lane_be : 4'b0000;

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk_i),
        .addr  (addr_reg[AW+1:2]),
        .be    (ram_be),
        .wdata (lane_wdata),
        .rdata (ram_rdata)
    );

    // Bring the addressed lane(s) down to bit 0, then extend.
    assign aligned = ram_rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        read_ext = aligned;
        case (size_reg)
            SZ_BYTE: read_ext = {{24{!uns_reg && aligned[7]}},  aligned[7:0]};
            SZ_HALF: read_ext = {{16{!uns_reg && aligned[15]}}, aligned[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            size_reg  <= SZ_BYTE;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= 32'd0;
                    if (bus.req_i) begin
                        addr_reg  <= bus.addr_i;
                        wdata_reg <= bus.data_i;
                        size_reg  <= bus.size_i;
                        we_reg    <= bus.we_i;
                        uns_reg   <= bus.unsigned_i;
                        cnt_reg   <= CNT_INIT;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 3'd0) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_DONE;
                        if (access_err) begin
                            err_reg   <= 1'b1;
                            rdata_reg <= 32'd0;
                        end else begin
                            valid_reg <= 1'b1;
                            rdata_reg <= we_reg ? 32'd0 : read_ext;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                ST_DONE: begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= 32'd0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= 32'd0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o  = busy_reg;
    assign bus.valid_o = valid_reg;
    assign bus.err_o   = err_reg;
    assign bus.data_o  = rdata_reg;

endmodule

// File: tb/tb_dmem_sync.sv
// Randomised self-checking bench for dmem_sync. Two instances share a clock:
// index 0 runs LATENCY=1, index 1 runs LATENCY=4, both DEPTH_WORDS=32.
// A byte-array reference model predicts every response.
module tb_dmem_sync;
    import dmem_pkg::*;

    localparam int DEPTH = 32;
    localparam int NBYTES = 4 * DEPTH;

    logic clk;
    logic rst1;
    logic rst4;

    dmem_sync_if bus1();
    dmem_sync_if bus4();

    dmem_sync #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst1),
        .bus   (bus1)
    );

    dmem_sync #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst4),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lat [2]  = '{1, 4};
    logic [7:0] mem_m [2][NBYTES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] size);
        return (size == SZ_BYTE) ? 1 : (size == SZ_HALF) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == SZ_RSVD) return 1'b1;
        if (longint'(addr) >= NBYTES) return 1'b1;
        if (addr % size_bytes(size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr);
        longint unsigned v;
        int nb;
        v  = 0;
        nb = size_bytes(size);
        for (int i = 0; i < nb; i++)
            v = v + (longint'(mem_m[d][int'(addr) + i]) << (8 * i));
        if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    task automatic model_write(input int d, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata);
        for (int i = 0; i < size_bytes(size); i++)
            mem_m[d][int'(addr) + i] = 8'(wdata >> (8 * i));
    endtask

    // ---------------- bus helpers ----------------
    task automatic drive(input int d, input logic req, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (d == 0) begin
            bus1.req_i = req; bus1.we_i = we; bus1.size_i = size;
            bus1.unsigned_i = uns; bus1.addr_i = addr; bus1.data_i = wdata;
        end else begin
            bus4.req_i = req; bus4.we_i = we; bus4.size_i = size;
            bus4.unsigned_i = uns; bus4.addr_i = addr; bus4.data_i = wdata;
        end
    endtask

    task automatic sample(input int d, output logic b, output logic v,
                          output logic e, output logic [31:0] q);
        if (d == 0) begin
            b = bus1.busy_o; v = bus1.valid_o; e = bus1.err_o; q = bus1.data_o;
        end else begin
            b = bus4.busy_o; v = bus4.valid_o; e = bus4.err_o; q = bus4.data_o;
        end
    endtask

    // One complete access: request, wait for the completion pulse, check
    // latency / busy span / response, then check the return to idle.
    task automatic access(input int d, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input string tag, output logic [31:0] q);
        logic b, v, e, exp_err;
        logic [31:0] exp_q;
        int n, nbusy;
        exp_err = model_err(size, addr);
        exp_q   = (we || exp_err) ? 32'd0 : model_read(d, size, uns, addr);

        @(negedge clk);
        drive(d, 1'b1, we, size, uns, addr, wdata);
        @(posedge clk);
        #1;
        drive(d, 1'b0, we, size, uns, addr, wdata);
        sample(d, b, v, e, q);
        nbusy = b ? 1 : 0;
        n = 0;
        v = 1'b0;
        e = 1'b0;
        while (!(v || e) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            sample(d, b, v, e, q);
            if (!(v || e) && b) nbusy++;
        end
        $display("%s L%0d we=%0d sz=%0d uns=%0d addr=%h wd=%h -> lat=%0d valid=%0d err=%0d q=%h",
                 tag, lat[d], we, size, uns, addr, wdata, n, v, e, q);
        check($sformatf("%s_latency", tag), 32'(n), 32'(lat[d]));
        check($sformatf("%s_busy_cycles", tag), 32'(nbusy), 32'(lat[d]));
        check($sformatf("%s_busy_done", tag), {31'd0, b}, 32'd0);
        check($sformatf("%s_valid", tag), {31'd0, v}, {31'd0, !exp_err});
        check($sformatf("%s_err", tag), {31'd0, e}, {31'd0, exp_err});
        check($sformatf("%s_data", tag), q, exp_q);
        if (we && !exp_err) model_write(d, size, addr, wdata);

        @(posedge clk);
        #1;
        begin
            logic b2, v2, e2;
            logic [31:0] q2;
            sample(d, b2, v2, e2, q2);
            check($sformatf("%s_idle_pulse", tag), {29'd0, b2, v2, e2}, 32'd0);
            check($sformatf("%s_idle_data", tag), q2, 32'd0);
        end
    endtask

    task automatic check_quiet(input int d, input string tag);
        logic b, v, e;
        logic [31:0] q;
        sample(d, b, v, e, q);
        check($sformatf("%s_ctrl", tag), {29'd0, b, v, e}, 32'd0);
        check($sformatf("%s_data", tag), q, 32'd0);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] old_word;
        rst1 = 1'b0;
        rst4 = 1'b0;
        drive(0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'd0, 32'd0);
        #12;
        check_quiet(0, "reset_l1");
        check_quiet(1, "reset_l4");
        @(negedge clk);
        rst1 = 1'b1;
        rst4 = 1'b1;

        // Fill both memories so every later read has a defined model value.
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                access(d, 1'b1, SZ_WORD, 1'b0, 32'(4 * w), $urandom, "init", q);

        // Directed cases on the LATENCY=1 instance
        access(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, "wr_word", q);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, "rd_word", q);
        check("rd_word_const", q, 32'hDEADBEEF);
        access(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0, "rd_byte_s", q);
        check("rd_byte_s_const", q, 32'hFFFFFFDE);
        access(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0, "rd_byte_u", q);
        check("rd_byte_u_const", q, 32'h000000DE);
        access(0, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'd0, "rd_half_s", q);
        check("rd_half_s_const", q, 32'hFFFFBEEF);
        access(0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000005A, "wr_byte", q);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, "rd_merge", q);
        check("rd_merge_const", q, 32'hDEAD5AEF);

        // Rejected accesses, as writes aimed at the word at 0x10 and as reads
        access(0, 1'b1, SZ_WORD, 1'b0, 32'h12, 32'h11111111, "err_w_word", q);
        access(0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h22222222, "err_w_half", q);
        access(0, 1'b1, SZ_RSVD, 1'b0, 32'h10, 32'h33333333, "err_w_rsvd", q);
        access(0, 1'b1, SZ_WORD, 1'b0, 32'h80, 32'h44444444, "err_w_range", q);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'd0, "err_r_word", q);
        access(0, 1'b0, SZ_HALF, 1'b1, 32'h11, 32'd0, "err_r_half", q);
        access(0, 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'd0, "err_r_rsvd", q);
        access(0, 1'b0, SZ_BYTE, 1'b0, 32'h80, 32'd0, "err_r_range", q);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, "rd_after_err", q);
        check("rd_after_err_const", q, 32'hDEAD5AEF);

        // Request held high for three reads: accepted every third edge
        begin
            logic [31:0] hold_addr [3] = '{32'h00, 32'h04, 32'h08};
            logic [31:0] hold_exp [3];
            logic b, v, e, prev_b;
            int acc, pulses;
            for (int i = 0; i < 3; i++) hold_exp[i] = model_read(0, SZ_WORD, 1'b0, hold_addr[i]);
            acc = 0;
            pulses = 0;
            prev_b = 1'b0;
            @(negedge clk);
            drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, hold_addr[0], 32'd0);
            for (int edge_n = 1; edge_n <= 12; edge_n++) begin
                @(posedge clk);
                #1;
                sample(0, b, v, e, q);
                if (b && !prev_b) begin
                    check("hold_accept_edge", 32'(edge_n), 32'(1 + 3 * acc));
                    acc++;
                    if (acc < 3) drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, hold_addr[acc], 32'd0);
                    else         drive(0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'd0);
                end
                if (v) begin
                    $display("hold L1 pulse=%0d edge=%0d q=%h", pulses, edge_n, q);
                    if (pulses < 3) check("hold_data", q, hold_exp[pulses]);
                    pulses++;
                end
                prev_b = b;
            end
            check("hold_accepts", 32'(acc), 32'd3);
            check("hold_pulses", 32'(pulses), 32'd3);
        end

        // LATENCY=4: reset two edges after acceptance aborts the write
        old_word = model_read(1, SZ_WORD, 1'b0, 32'h20);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, ~old_word);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, ~old_word);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        #1;
        $display("abort L4 write addr=00000020 wd=%h reset asserted", ~old_word);
        check_quiet(1, "abort_now");
        repeat (3) @(posedge clk);
        #1;
        check_quiet(1, "abort_held");
        @(posedge clk);
        #2;
        rst4 = 1'b1;
        access(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0, "rd_after_abort", q);
        check("rd_after_abort_old", q, old_word);

        // Randomised traffic on both instances
        for (int i = 0; i < 240; i++) begin
            int d, sz;
            logic we, uns;
            logic [1:0] size;
            logic [31:0] addr;
            d    = i % 2;
            sz   = $urandom_range(0, 9);
            size = (sz < 3) ? SZ_BYTE : (sz < 6) ? SZ_HALF : (sz < 9) ? SZ_WORD : SZ_RSVD;
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, NBYTES + 15));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            access(d, we, size, uns, addr, $urandom, "rand", q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_sync.md
DMEM_SYNC -- requirements
Module: dmem_sync

Interface
REQ-001 Parameter DEPTH_WORDS, default 32, memory size in 32-bit words; power of two, 4..4096.
REQ-002 Parameter LATENCY, default 1, edges from request acceptance to completion; range 1..7.
REQ-003 clk_i  input  1  the only clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  access request, sampled only while busy_o is low.
REQ-006 we_i  input  1  1 = write, 0 = read; qualifies req_i.
REQ-007 size_i  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 unsigned_i  input  1  read extension: 1 = zero-extend, 0 = sign-extend.
REQ-009 addr_i  input  32  byte address, little-endian.
REQ-010 data_i  input  32  write data, right-aligned: byte in [7:0], half in [15:0].
REQ-011 busy_o  output  1  high while an accepted access is in flight (stall to pipeline).
REQ-012 valid_o  output  1  one-cycle completion pulse for reads and writes.
REQ-013 data_o  output  32  read data, extended per size/unsigned; 0 for writes and errors.
REQ-014 err_o  output  1  one-cycle pulse in place of valid_o for a rejected access.

Function
REQ-015 FSM states: IDLE, WAIT, DONE; busy_o = (state == WAIT), registered.
REQ-016 IDLE with req_i=1 at edge E0: latch addr/data/size/we/unsigned, load counter = LATENCY-1, go WAIT.
REQ-017 WAIT: counter decrements each edge; at the edge where it is 0 perform the access, go DONE.
REQ-018 DONE lasts one cycle: valid_o=1 (or err_o=1), data_o driven; next edge returns to IDLE.
REQ-019 Accepted access at E0 completes at edge E0+LATENCY; valid_o high in the cycle after that edge.
REQ-020 req_i while busy_o=1 or in DONE is ignored; the requester holds req_i until accepted.
REQ-021 Error: size_i=3, half with addr[0]=1, word with addr[1:0]!=0, or addr >= 4*DEPTH_WORDS.
REQ-022 On error: no memory write, data_o=0, err_o pulses in the DONE cycle, valid_o stays 0.
REQ-023 Writes update only the addressed byte lanes; other lanes of the word unchanged.
REQ-024 Reads return bytes at the addressed lanes, extended to 32 bits per unsigned_i.
REQ-025 Read of a location written by the immediately preceding access returns the new data.
REQ-026 valid_o and err_o never high in the same cycle; outside DONE both are 0 and data_o=0.

Reset
REQ-027 rst_i low forces state=IDLE, counter=0, busy_o=0, valid_o=0, err_o=0, data_o=0 immediately.
REQ-028 Reset during WAIT aborts the access; no write is committed and no pulse is produced.
REQ-029 Memory array contents are not reset and are undefined until written.
REQ-030 First request is accepted at the first rising edge after rst_i deasserts.

Structure
REQ-031 Shared package dmem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-032 Sub-module dmem_byte_ram: DEPTH_WORDS x 4 byte lanes, 4-bit byte write enable, synchronous write, combinational read.
REQ-033 Lane/enable generation, extension, error check and FSM live in dmem_sync.

Verification
REQ-034 LATENCY=1: write word 0xDEADBEEF at 0x10, read word 0x10 -> valid_o after 1 edge each, data_o=0xDEADBEEF, busy_o high 1 cycle per access.
REQ-035 After REQ-034: read byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; half 0x10 signed -> 0xFFFFBEEF.
REQ-036 Write byte 0x5A at 0x11, read word 0x10 -> 0xDEAD5AEF (other lanes intact).
REQ-037 Word read at 0x12, half at 0x11, size=3, addr=0x80 (DEPTH 32) -> err_o pulse, data_o=0, target memory unchanged.
REQ-038 LATENCY=4: write issued, rst_i pulled low 2 edges later -> outputs 0 at once, readback after reset shows old value.
REQ-039 Hold req_i continuously for 3 reads at LATENCY=1 -> accepted at every 3rd edge, exactly 3 valid_o pulses, no request dropped or duplicated.
